fork_three_fifo: RTL and testbench

Stream fork with three FIFOs: one valid/ready input stream is buffered, and every accepted word is delivered once to each of two independent valid/ready output streams (A and B), each with its own output FIFO. It is the dispatch-side counterpart of the adder join block. A slow or stalled consumer on one branch does not block the other branch until that branch's output FIFO fills.

---
 rtl/fork_three_fifo_if.sv | 11 +
 rtl/fork_three_fifo.sv | 162 ++++++++++++++++
 tb/tb_fork_three_fifo.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fork_three_fifo_if.sv
// Valid/ready stream bundle used for the fork input and both branch outputs.
interface fork_three_fifo_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fork_three_fifo.sv
// Stream fork: input FIFO feeds two independent branch FIFOs; each accepted
// word is delivered exactly once, in order, to both branch A and branch B.

module fork_three_fifo_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          wr_en;
    logic          rd_en;

    // Pointer MSB is the wrap bit: equal pointers mean empty, differing wrap means full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en = push_i && !full_o;
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; contents are only observable behind a valid pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

module fork_three_fifo #(
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    fork_three_fifo_if.slave    d,
    fork_three_fifo_if.master   a,
    fork_three_fifo_if.master   b
);
    logic          in_push, in_pop, in_empty, in_full;
    logic [DW-1:0] in_head;
    logic          a_push, a_pop, a_empty, a_full;
    logic [DW-1:0] a_head;
    logic          b_push, b_pop, b_empty, b_full;
    logic [DW-1:0] b_head;
    logic          done_a, done_b;
    logic          sent_a_q, sent_a_d;
    logic          sent_b_q, sent_b_d;

    fork_three_fifo_buf #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_push),
        .wdata_i (d.data),
        .pop_i   (in_pop),
        .rdata_o (in_head),
        .empty_o (in_empty),
        .full_o  (in_full)
    );

    fork_three_fifo_buf #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_a_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (a_push),
        .wdata_i (in_head),
        .pop_i   (a_pop),
        .rdata_o (a_head),
        .empty_o (a_empty),
        .full_o  (a_full)
    );

    fork_three_fifo_buf #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (b_push),
        .wdata_i (in_head),
        .pop_i   (b_pop),
        .rdata_o (b_head),
        .empty_o (b_empty),
        .full_o  (b_full)
    );

    // Handshakes derive only from registered FIFO state, never from the peer's valid/ready.
    assign d.ready = !in_full;
    assign a.valid = !a_empty;
    assign a.data  = a_head;
    assign b.valid = !b_empty;
    assign b.data  = b_head;

    assign in_push = d.valid && !in_full;
    assign a_pop   = !a_empty && a.ready;
    assign b_pop   = !b_empty && b.ready;

    // Fork stage: the IN head leaves only once both branches have taken it.
    always_comb begin
        a_push   = 1'b0;
        b_push   = 1'b0;
        done_a   = 1'b0;
        done_b   = 1'b0;
        in_pop   = 1'b0;
        sent_a_d = sent_a_q;
        sent_b_d = sent_b_q;

        a_push = !in_empty && !sent_a_q && !a_full;
        b_push = !in_empty && !sent_b_q && !b_full;
        done_a = sent_a_q || a_push;
        done_b = sent_b_q || b_push;
        in_pop = !in_empty && done_a && done_b;

        if (in_pop) begin
            sent_a_d = 1'b0;
            sent_b_d = 1'b0;
        end else begin
            sent_a_d = sent_a_q || a_push;
            sent_b_d = sent_b_q || b_push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_a_q <= 1'b0;
            sent_b_q <= 1'b0;
        end else begin
            sent_a_q <= sent_a_d;
            sent_b_q <= sent_b_d;
        end
    end
endmodule

// File: tb/tb_fork_three_fifo.sv
// Scoreboard bench for fork_three_fifo: accepted input words are queued for
// both branches and a negedge monitor checks every branch handshake.
module tb_fork_three_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic clk;
    logic rst;

    fork_three_fifo_if #(.DW(DW)) d_if ();
    fork_three_fifo_if #(.DW(DW)) a_if ();
    fork_three_fifo_if #(.DW(DW)) b_if ();

    fork_three_fifo #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d_if),
        .a   (a_if),
        .b   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int rx_a     = 0;
    int rx_b     = 0;
    int ra_mode  = 1;   // 0: ready low, 1: ready high, 2: random
    int rb_mode  = 1;
    logic [DW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Branch monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.valid && a_if.ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected actual=%h required=none", a_if.data);
                end else begin
                    check("a_data", a_if.data, exp_a.pop_front());
                end
                rx_a++;
            end
            if (b_if.valid && b_if.ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected actual=%h required=none", b_if.data);
                end else begin
                    check("b_data", b_if.data, exp_b.pop_front());
                end
                rx_b++;
            end
        end
    end

    // One cycle: drive at posedge+1, record acceptance at negedge, return at next posedge+1.
    task automatic drive_cycle(input bit v, input logic [DW-1:0] w, output bit acc);
        d_if.valid = v;
        d_if.data  = w;
        a_if.ready = (ra_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ra_mode);
        b_if.ready = (rb_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rb_mode);
        @(negedge clk);
        acc = v && d_if.ready;
        if (acc) begin
            exp_a.push_back(w);
            exp_b.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, acc);
    endtask

    task automatic offer(input logic [DW-1:0] w, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) drive_cycle(1'b1, w, ok);
    endtask

    task automatic drain(input string name, input int budget);
        bit acc;
        ra_mode = 1;
        rb_mode = 1;
        for (int i = 0; i < budget && (exp_a.size() != 0 || exp_b.size() != 0); i++)
            drive_cycle(1'b0, '0, acc);
        idle(2);
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            failures++;
            $display("FAIL %s actual=pending_a:%0d,pending_b:%0d required=0,0",
                     name, exp_a.size(), exp_b.size());
        end
        check({name, "_a_valid_idle"}, 32'(a_if.valid), 32'd0);
        check({name, "_b_valid_idle"}, 32'(b_if.valid), 32'd0);
    endtask

    initial begin
        bit acc;
        int idx;
        int base_a;
        int base_b;
        int sent;

        rst        = 1'b1;
        d_if.valid = 1'b0;
        d_if.data  = '0;
        a_if.ready = 1'b0;
        b_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_ready", 32'(d_if.ready), 32'd1);
        check("reset_a_valid", 32'(a_if.valid), 32'd0);
        check("reset_b_valid", 32'(b_if.valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in mid-cycle with words buffered in the branches.
        ra_mode = 0;
        rb_mode = 0;
        drive_cycle(1'b1, 32'hA1, acc);
        drive_cycle(1'b1, 32'hA2, acc);
        drive_cycle(1'b1, 32'hA3, acc);
        idle(2);
        check("pre_rst_a_valid", 32'(a_if.valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_d_ready", 32'(d_if.ready), 32'd1);
        check("async_rst_a_valid", 32'(a_if.valid), 32'd0);
        check("async_rst_b_valid", 32'(b_if.valid), 32'd0);
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Accept-to-output latency of two cycles.
        ra_mode = 1;
        rb_mode = 1;
        drive_cycle(1'b1, 32'h11, acc);
        check("lat_accept", 32'(acc), 32'd1);
        check("lat_a_valid_n", 32'(a_if.valid), 32'd0);
        check("lat_b_valid_n", 32'(b_if.valid), 32'd0);
        idle(1);
        check("lat_a_valid_n1", 32'(a_if.valid), 32'd1);
        check("lat_b_valid_n1", 32'(b_if.valid), 32'd1);
        check("lat_a_data", a_if.data, 32'h11);
        check("lat_b_data", b_if.data, 32'h11);
        drain("lat_drain", 20);

        // Back-to-back streaming with both consumers ready.
        base_a = rx_a;
        base_b = rx_b;
        idx = 0;
        for (int i = 1; i <= 64; i++) begin
            drive_cycle(1'b1, 32'(i), acc);
            if (acc) idx++;
        end
        check("stream_accepts", 32'(idx), 32'd64);
        drain("stream_drain", 50);
        check("stream_rx_a", 32'(rx_a - base_a), 32'd64);
        check("stream_rx_b", 32'(rx_b - base_b), 32'd64);

        // Branch B stalled: B FIFO plus IN hold 32 words; A sees the B-FIFO words plus the IN head.
        ra_mode = 1;
        rb_mode = 0;
        base_a = rx_a;
        base_b = rx_b;
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            drive_cycle(idx < 48, 32'h100 + 32'(idx), acc);
            if (acc) idx++;
        end
        check("bstall_accepts", 32'(idx), 32'd32);
        check("bstall_d_ready", 32'(d_if.ready), 32'd0);
        check("bstall_rx_a", 32'(rx_a - base_a), 32'd17);
        check("bstall_rx_b", 32'(rx_b - base_b), 32'd0);
        rb_mode = 1;
        while (idx < 48) begin
            offer(32'h100 + 32'(idx), 20, acc);
            if (!acc) break;
            idx++;
        end
        check("bstall_all_accepted", 32'(idx), 32'd48);
        drain("bstall_drain", 100);
        check("bstall_final_a", 32'(rx_a - base_a), 32'd48);
        check("bstall_final_b", 32'(rx_b - base_b), 32'd48);

        // Both branches stalled: capacity is exactly 2*DEPTH.
        ra_mode = 0;
        rb_mode = 0;
        base_a = rx_a;
        base_b = rx_b;
        idx = 0;
        for (int c = 0; c < 45; c++) begin
            drive_cycle(idx < 40, 32'h200 + 32'(idx), acc);
            if (acc) begin
                idx++;
                if (idx == 32) check("both_d_ready_after_32", 32'(d_if.ready), 32'd0);
            end
        end
        check("both_accepts", 32'(idx), 32'd32);
        check("both_d_ready_end", 32'(d_if.ready), 32'd0);
        drain("both_drain", 100);
        check("both_rx_a", 32'(rx_a - base_a), 32'd32);
        check("both_rx_b", 32'(rx_b - base_b), 32'd32);

        // A full with a pending word already sent to B; one A pop lets it through.
        ra_mode = 0;
        rb_mode = 1;
        base_a = rx_a;
        base_b = rx_b;
        for (int i = 0; i < 20; i++) begin
            offer(32'h300 + 32'(i), 10, acc);
            check("afull_offer", 32'(acc), 32'd1);
        end
        idle(5);
        check("afull_rx_a", 32'(rx_a - base_a), 32'd0);
        check("afull_rx_b", 32'(rx_b - base_b), 32'd17);
        ra_mode = 1;
        idle(1);
        ra_mode = 0;
        idle(3);
        check("afull_pulse_rx_a", 32'(rx_a - base_a), 32'd1);
        check("afull_pulse_rx_b", 32'(rx_b - base_b), 32'd18);
        check("afull_a_valid", 32'(a_if.valid), 32'd1);
        check("afull_d_ready", 32'(d_if.ready), 32'd1);
        drain("afull_drain", 100);
        check("afull_final_a", 32'(rx_a - base_a), 32'd20);
        check("afull_final_b", 32'(rx_b - base_b), 32'd20);

        // Random valid/ready at 50% across many pointer wraps.
        ra_mode = 2;
        rb_mode = 2;
        base_a = rx_a;
        base_b = rx_b;
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            drive_cycle(1'($urandom_range(0, 1)), 32'($urandom), acc);
            if (acc) sent++;
        end
        check("rand_sent", 32'(sent), 32'd10000);
        drain("rand_drain", 200);
        check("rand_rx_a", 32'(rx_a - base_a), 32'(sent));
        check("rand_rx_b", 32'(rx_b - base_b), 32'(sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
